// File: rtl/div_seq_ctrl.sv
// Multi-cycle DIV/DIVU sequencer for the execute stage: 32-step restoring
// divide with MIPS sign rules, a defined divide-by-zero result and stall/annul handling.
module div_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        annul,
  output logic [63:0] div_result,
  output logic        div_ready,
  output logic        div_busy,
  output logic        stallreq_div
);

  typedef enum logic [1:0] {IDLE, BUSY, ZERO, DONE} state_t;

  state_t      state, state_nxt;
  logic        sgn, dvd_neg, quo_neg;
  logic [31:0] dvd, dvs, quo, rem, dividend_raw;
  logic [4:0]  cnt;

  logic        accept, abort, last_iter, fits;
  logic [32:0] rem_sh, rem_sub;
  logic [31:0] rem_nxt, quo_nxt, quo_fix, rem_fix;
  logic [31:0] dividend_mag, divisor_mag;

  assign accept    = (state == IDLE) & div_start & ~annul;
  assign abort     = annul | ~div_start;
  assign last_iter = (cnt == 5'd31);

  assign div_busy     = (state == BUSY) | (state == ZERO);
  assign stallreq_div = div_start & ~annul & ~div_ready & ~rst;

  assign dividend_mag = (div_signed & dividend[31]) ? (~dividend + 32'd1) : dividend;
  assign divisor_mag  = (div_signed & divisor[31])  ? (~divisor + 32'd1)  : divisor;

  // The 33-bit borrow doubles as the rem >= dvs compare: the shifted
  // remainder is always below 2*dvs, so bit 32 of the difference is set only when it does not fit.
  always_comb begin
    rem_sh  = {rem, dvd[31]};
    rem_sub = rem_sh - {1'b0, dvs};
    fits    = ~rem_sub[32];
    rem_nxt = fits ? rem_sub[31:0] : rem_sh[31:0];
    quo_nxt = fits ? (quo | (32'h8000_0000 >> cnt)) : quo;
    quo_fix = (sgn & quo_neg) ? (~quo_nxt + 32'd1) : quo_nxt;
    rem_fix = (sgn & dvd_neg) ? (~rem_nxt + 32'd1) : rem_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (divisor == 32'd0) ? ZERO : BUSY;
      BUSY: begin
        if (abort)          state_nxt = IDLE;
        else if (last_iter) state_nxt = DONE;
      end
      ZERO: state_nxt = abort ? IDLE : DONE;
      DONE: if (abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Aborted runs never touch div_result, so it keeps the last completed value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sgn          <= 1'b0;
      dvd_neg      <= 1'b0;
      quo_neg      <= 1'b0;
      dvd          <= '0;
      dvs          <= '0;
      quo          <= '0;
      rem          <= '0;
      dividend_raw <= '0;
      cnt          <= '0;
      div_result   <= '0;
      div_ready    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sgn          <= div_signed;
            dvd_neg      <= dividend[31];
            quo_neg      <= dividend[31] ^ divisor[31];
            dvd          <= dividend_mag;
            dvs          <= divisor_mag;
            dividend_raw <= dividend;
            quo          <= '0;
            rem          <= '0;
            cnt          <= '0;
          end
        end
        BUSY: begin
          if (!abort) begin
            rem <= rem_nxt;
            dvd <= {dvd[30:0], 1'b0};
            quo <= quo_nxt;
            cnt <= cnt + 5'd1;
            if (last_iter) begin
              div_result <= {rem_fix, quo_fix};
              div_ready  <= 1'b1;
            end
          end
        end
        ZERO: begin
          if (!abort) begin
            div_result <= {dividend_raw, 32'hFFFF_FFFF};
            div_ready  <= 1'b1;
          end
        end
        DONE: if (abort) div_ready <= 1'b0;
        default: div_ready <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: expected results go into a scoreboard
// queue when a divide is requested and are popped when div_ready rises.
module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start;
  logic        div_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        annul;
  logic [63:0] div_result;
  logic        div_ready;
  logic        div_busy;
  logic        stallreq_div;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_result;

  div_seq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .div_start    (div_start),
    .div_signed   (div_signed),
    .dividend     (dividend),
    .divisor      (divisor),
    .annul        (annul),
    .div_result   (div_result),
    .div_ready    (div_ready),
    .div_busy     (div_busy),
    .stallreq_div (stallreq_div)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    la = sgn ? longint'($signed(a)) : longint'(a);
    lb = sgn ? longint'($signed(b)) : longint'(b);
    if (la < 0) la = -la;
    if (lb < 0) lb = -lb;
    q = la / lb;
    r = la % lb;
    if (sgn && (a[31] ^ b[31])) q = -q;
    if (sgn && a[31]) r = -r;
    return {r[31:0], q[31:0]};
  endfunction

  // Full request/response: counts stall cycles and latency, then drops div_start one cycle.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] expected, input int exp_cycles,
                         input bit scramble, input string name);
    int cycles, stall_cnt;
    logic [63:0] want;
    div_signed = sgn;
    dividend   = a;
    divisor    = b;
    annul      = 1'b0;
    div_start  = 1'b1;
    exp_q.push_back(expected);
    #1;
    cycles    = 0;
    stall_cnt = 0;
    while (!div_ready && cycles < 100) begin
      if (stallreq_div) stall_cnt++;
      @(posedge clk); #1;
      cycles++;
      if (scramble) begin
        dividend   = $urandom;
        divisor    = $urandom;
        div_signed = 1'($urandom_range(0, 1));
      end
    end
    checks++;
    if (div_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s ready_timeout: got div_ready=%b after %0d cycles want 1", name, div_ready, cycles);
    end
    checks++;
    if (cycles != exp_cycles) begin
      failures++;
      $display("[TB] FAIL %s latency: got %0d want %0d", name, cycles, exp_cycles);
    end
    checks++;
    if (stall_cnt != exp_cycles) begin
      failures++;
      $display("[TB] FAIL %s stall_cycles: got %0d want %0d", name, stall_cnt, exp_cycles);
    end
    checks++;
    if (stallreq_div !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s stall_on_ready: got %b want 0", name, stallreq_div);
    end
    want = exp_q.pop_front();
    checks++;
    if (div_result !== want) begin
      failures++;
      $display("[TB] FAIL %s result: got %h want %h", name, div_result, want);
    end
    last_result = want;
    div_start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (div_ready !== 1'b0 || div_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s release: got ready=%b busy=%b want 0 0", name, div_ready, div_busy);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    div_start  = 1'b1;
    annul      = 1'b0;
    div_signed = 1'b0;
    dividend   = 32'd10;
    divisor    = 32'd2;
    #12;
    checks++;
    if (div_result !== 64'd0 || div_ready !== 1'b0 || div_busy !== 1'b0 || stallreq_div !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_values: got result=%h ready=%b busy=%b stall=%b want 0 0 0 0",
               div_result, div_ready, div_busy, stallreq_div);
    end
    @(negedge clk);
    rst       = 1'b0;
    div_start = 1'b0;
    @(posedge clk); #1;
    last_result = 64'd0;
  endtask

  task automatic test_basic();
    run_div(1'b1, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b0, "s_100_7");
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1'b0, "s_m7_2");
    run_div(1'b0, 32'hFFFF_FFFF, 32'd2, {32'd1, 32'h7FFF_FFFF}, 33, 1'b0, "u_max_2");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33, 1'b0, "s_overflow");
    run_div(1'b1, 32'h0000_1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF}, 2, 1'b0, "div_by_zero");
  endtask

  task automatic test_annul();
    bit ready_seen;
    div_signed = 1'b0;
    dividend   = 32'd1000;
    divisor    = 32'd3;
    annul      = 1'b0;
    div_start  = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (div_busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL annul_accept: got busy=%b want 1", div_busy);
    end
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1;
    div_start = 1'b0;
    @(posedge clk); #1;
    annul = 1'b0;
    checks++;
    if (div_busy !== 1'b0 || div_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL annul_idle: got busy=%b ready=%b want 0 0", div_busy, div_ready);
    end
    ready_seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (div_ready) ready_seen = 1'b1;
    end
    checks++;
    if (ready_seen) begin
      failures++;
      $display("[TB] FAIL annul_no_ready: got ready seen=1 want 0");
    end
    checks++;
    if (div_result !== last_result) begin
      failures++;
      $display("[TB] FAIL annul_result_held: got %h want %h", div_result, last_result);
    end
    div_start = 1'b1;
    annul     = 1'b1;
    #1;
    checks++;
    if (stallreq_div !== 1'b0) begin
      failures++;
      $display("[TB] FAIL annul_with_start_stall: got %b want 0", stallreq_div);
    end
    @(posedge clk); #1;
    checks++;
    if (div_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL annul_with_start_accept: got busy=%b want 0", div_busy);
    end
    div_start = 1'b0;
    annul     = 1'b0;
    @(posedge clk); #1;
    run_div(1'b0, 32'd5, 32'd5, {32'd0, 32'd1}, 33, 1'b0, "redo_5_5");
  endtask

  task automatic test_reset_mid();
    div_signed = 1'b0;
    dividend   = 32'd1000;
    divisor    = 32'd7;
    annul      = 1'b0;
    div_start  = 1'b1;
    @(posedge clk); #1;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (div_result !== 64'd0 || div_ready !== 1'b0 || div_busy !== 1'b0 || stallreq_div !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid: got result=%h ready=%b busy=%b stall=%b want 0 0 0 0",
               div_result, div_ready, div_busy, stallreq_div);
    end
    last_result = 64'd0;
    @(posedge clk); #1;
    rst       = 1'b0;
    div_start = 1'b0;
    @(posedge clk); #1;
    run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 1'b0, "after_reset_9_3");
  endtask

  task automatic test_back_to_back();
    run_div(1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33, 1'b1, "b2b_50_5");
    run_div(1'b0, 32'd51, 32'd5, {32'd1, 32'd10}, 33, 1'b1, "b2b_51_5");
  endtask

  task automatic test_random();
    logic        s;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000)));
      run_div(s, a, b, model_div(s, a, b), (b == 32'd0) ? 2 : 33, 1'b0, $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
